uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   8N1 UART receiver for the Xyloni board RXD pin (FTDI USB-UART bridge).
//   Oversamples the async serial line, recovers bytes, and presents each on a
//   valid/ready byte interface to the top-level application logic.
//   Flags framing errors and overruns.
//   Feeds the design's top level and is the RX counterpart to the TXD path.
// PARAMETERS
//   CLK_HZ      33_333_333  i_sysclk frequency in Hz
//   BAUD        115200      line rate in bit/s
//   OVERSAMPLE  16          ticks per bit; must be even and >= 8
//   DIV = round(CLK_HZ/(BAUD*OVERSAMPLE)), derived, must be >= 1 (18 at defaults)
// PORTS
//   i_sysclk      in   1  system clock
//   i_rstn        in   1  reset: synchronous, active-low
//   i_rxd         in   1  async serial input, idle high
//   o_data        out  8  received byte, stable while o_valid=1
//   o_valid       out  1  byte available; held until accepted
//   i_ready       in   1  consumer accepts byte when o_valid & i_ready
//   o_frame_err   out  1  one-cycle pulse: stop bit sampled low
//   o_overrun     out  1  one-cycle pulse: byte completed while o_valid & !i_ready
//   o_busy        out  1  high in any state other than IDLE
// BEHAVIOUR
//   Reset (i_rstn=0 at posedge): o_data=0, o_valid=0, o_frame_err=0, o_overrun=0,
//     o_busy=0; synchroniser flops = 1; FSM=IDLE; counters=0. Reset mid-frame aborts it.
//   Input: 2-flop synchroniser on i_rxd; the FSM sees only the 2nd flop (rx_s).
//   Tick: divider counts 0..DIV-1 and pulses tick on DIV-1. It is cleared on IDLE->START
//     so that sampling phase aligns to the detected start edge.
//   FSM (advances only on tick, except IDLE which acts on every clock):
//     IDLE  : rx_s==0 -> START; clear tick counter and sample counter.
//     START : after OVERSAMPLE/2 ticks (mid start bit), sample rx_s.
//             0 -> DATA with bit_idx=0. 1 -> IDLE (glitch rejection, no flag).
//     DATA  : every OVERSAMPLE ticks, sample rx_s into shift reg, LSB first.
//             After bit_idx==7 -> STOP.
//     STOP  : after OVERSAMPLE ticks (mid stop bit), sample rx_s.
//             1 -> commit byte, go IDLE.
//             0 -> o_frame_err pulse, byte discarded, go BRK.
//     BRK   : wait for rx_s==1, then go IDLE. Prevents a held-low line/break from
//             re-triggering.
//   Commit (cycle after the stop sample):
//     if !o_valid or i_ready: o_data<=shift, o_valid<=1.
//     else: o_overrun pulse, the old byte is kept, and the new byte is dropped.
//   Handshake: o_valid falls the cycle after o_valid&i_ready unless a commit
//     occurs in that same cycle (then o_valid stays 1 with the new byte, and no
//     overrun is flagged).
//   Latency: o_valid rises ~9.5 bit times + 3 clocks after the falling start edge
//     on i_rxd.
//   Back-to-back: returns to IDLE at mid stop bit, so the next start edge is
//     caught with no gap required.
//   Width: tick counter ceil(log2(DIV)), sample counter ceil(log2(OVERSAMPLE)),
//     bit_idx 3 bits; all counters wrap only by explicit clear.
// STRUCTURE
//   Package uart_pkg:
//     - FSM state localparams (IDLE, START, DATA, STOP, BRK)
//     - function calc_div(CLK_HZ, BAUD, OVERSAMPLE)
//     - constant DATA_BITS = 8
//     This package is shared with the future uart_tx.
//   Sub-module uart_baud_tick: parameter DIV; inputs i_sysclk, i_rstn, i_clr;
//     output o_tick. It is reused by uart_tx.
//   Everything else (synchroniser, FSM, shift reg, output register) is inline.
// TESTING
//   1 Reset, line idle 20 bit times -> o_valid=0, o_busy=0, no pulses.
//   2 Send 0x55 then 0xA3 back-to-back at 115200, i_ready=1 -> o_data 0x55 then
//     0xA3, each with a 1-cycle o_valid, no flags.
//   3 Low glitch of 0.25 bit on i_rxd -> o_busy pulses, then back to IDLE;
//     o_valid=0, o_frame_err=0.
//   4 Send 0x3C with stop bit forced low, then hold low 2 bytes -> a single
//     o_frame_err pulse, no o_valid; the FSM stays in BRK until the line is high.
//   5 i_ready=0, send 0x11, 0x22 -> o_valid=1 with 0x11; o_overrun pulses at the
//     0x22 stop; o_data remains 0x11.
//   6 Assert i_rstn=0 mid DATA bit 4 for 1 clock, then send 0x7E -> the first byte
//     is lost, and 0x7E is received correctly.
//   Also sweep the baud error at +/-3% on test 2 and check bytes are still correct.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and baud divider helper.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBrk
  } uart_state_e;

  // Clock cycles per oversample tick, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    int unsigned den;
    den = baud * oversample;
    return (clk_hz + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1 and pulses o_tick on the last count.
module uart_baud_tick #(
  parameter int unsigned DIV = 18
) (
  input  logic i_sysclk,
  input  logic i_rstn,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_sysclk) begin
    if (!i_rstn || i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = (r_cnt == LAST) && !i_clr;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampled mid-bit sampling and a valid/ready byte output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 33_333_333,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       i_sysclk,
  input  logic       i_rstn,
  input  logic       i_rxd,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int unsigned DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned SW  = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] HALF_M1 = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_M1 = SW'(OVERSAMPLE - 1);

  logic                 r_sync1;
  logic                 r_rx_s;
  uart_state_e          r_state;
  logic [SW-1:0]        r_scnt;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_commit;
  logic                 r_frame_err;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_overrun;
  logic                 w_tick;
  logic                 w_clr;

  // Holding the divider cleared in IDLE aligns tick phase to the start edge.
  assign w_clr = (r_state == StIdle);

  uart_baud_tick #(
    .DIV(DIV)
  ) u_baud_tick (
    .i_sysclk(i_sysclk),
    .i_rstn  (i_rstn),
    .i_clr   (w_clr),
    .o_tick  (w_tick)
  );

  always_ff @(posedge i_sysclk) begin
    if (!i_rstn) begin
      r_sync1     <= 1'b1;
      r_rx_s      <= 1'b1;
      r_state     <= StIdle;
      r_scnt      <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_commit    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync1     <= i_rxd;
      r_rx_s      <= r_sync1;
      r_commit    <= 1'b0;
      r_frame_err <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (!r_rx_s) begin
            r_state <= StStart;
            r_scnt  <= '0;
          end
        end
        StStart: begin
          if (w_tick) begin
            if (r_scnt == HALF_M1) begin
              r_scnt    <= '0;
              r_bit_idx <= '0;
              r_state   <= r_rx_s ? StIdle : StData;
            end else begin
              r_scnt <= r_scnt + SW'(1);
            end
          end
        end
        StData: begin
          if (w_tick) begin
            if (r_scnt == FULL_M1) begin
              r_scnt    <= '0;
              r_shift   <= {r_rx_s, r_shift[DATA_BITS-1:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
              if (r_bit_idx == 3'd7) r_state <= StStop;
            end else begin
              r_scnt <= r_scnt + SW'(1);
            end
          end
        end
        StStop: begin
          if (w_tick) begin
            if (r_scnt == FULL_M1) begin
              r_scnt <= '0;
              if (r_rx_s) begin
                r_commit <= 1'b1;
                r_state  <= StIdle;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= StBrk;
              end
            end else begin
              r_scnt <= r_scnt + SW'(1);
            end
          end
        end
        StBrk: begin
          if (w_tick && r_rx_s) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Output holding register; a commit during a handshake replaces the byte without overrun.
  always_ff @(posedge i_sysclk) begin
    if (!i_rstn) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_commit) begin
        if (!r_valid || i_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;
  assign o_busy      = (r_state != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a byte scoreboard fed by the serial stimulus.
`timescale 1ns / 1ps
module tb_uart_rx;

  localparam int BIT_NS = 8680;

  logic       i_sysclk = 1'b0;
  logic       i_rstn;
  logic       i_rxd;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;

  int n_cmp = 0;
  int n_err = 0;
  int n_fe = 0;
  int n_ov = 0;
  int n_vcyc = 0;
  bit busy_seen = 1'b0;
  logic [7:0] sb[$];

  always #15 i_sysclk = ~i_sysclk;

  uart_rx u_dut (
    .i_sysclk   (i_sysclk),
    .i_rstn     (i_rstn),
    .i_rxd      (i_rxd),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun),
    .o_busy     (o_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bit_ns);
    i_rxd = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      i_rxd = b[i];
      #(bit_ns);
    end
    i_rxd = stop_bit;
    #(bit_ns);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 4000) begin
      @(posedge i_sysclk);
      k++;
    end
    chk(tag, sb.size(), 0);
  endtask

  // Monitor: output pulses counted and accepted bytes checked against the scoreboard.
  initial begin
    logic [7:0] exp_b;
    forever begin
      @(negedge i_sysclk);
      if (i_rstn === 1'b1) begin
        if (o_valid) n_vcyc++;
        if (o_frame_err) n_fe++;
        if (o_overrun) n_ov++;
        if (o_busy) busy_seen = 1'b1;
        if (o_valid && i_ready) begin
          chk("sb_has_entry", {31'd0, sb.size() != 0}, 32'd1);
          if (sb.size() != 0) begin
            exp_b = sb.pop_front();
            chk("rx_byte", {24'd0, o_data}, {24'd0, exp_b});
          end
        end
      end
    end
  end

  initial begin
    int fe0, ov0, vc0;
    int sweep[3];
    sweep[0] = BIT_NS;
    sweep[1] = BIT_NS * 103 / 100;
    sweep[2] = BIT_NS * 97 / 100;
    i_rstn  = 1'b0;
    i_rxd   = 1'b1;
    i_ready = 1'b1;
    repeat (4) @(posedge i_sysclk);
    #1 i_rstn = 1'b1;
    @(posedge i_sysclk);
    #1;
    chk("rst_data", {24'd0, o_data}, 32'd0);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_frame_err", {31'd0, o_frame_err}, 32'd0);
    chk("rst_overrun", {31'd0, o_overrun}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);

    // 1: idle line
    #(20 * BIT_NS);
    chk("idle_valid", {31'd0, o_valid}, 32'd0);
    chk("idle_busy", {31'd0, o_busy}, 32'd0);
    chk("idle_vcyc", n_vcyc, 0);
    chk("idle_pulses", n_fe + n_ov, 0);

    // 2: back-to-back bytes, nominal and +/-3% line rate
    for (int s = 0; s < 3; s++) begin
      fe0 = n_fe;
      ov0 = n_ov;
      vc0 = n_vcyc;
      sb.push_back(8'h55);
      send_frame(8'h55, 1'b1, sweep[s]);
      sb.push_back(8'hA3);
      send_frame(8'hA3, 1'b1, sweep[s]);
      #(BIT_NS);
      drain("b2b_drain");
      chk("b2b_vcyc", n_vcyc - vc0, 2);
      chk("b2b_fe", n_fe - fe0, 0);
      chk("b2b_ov", n_ov - ov0, 0);
    end

    // 3: quarter-bit low glitch
    fe0 = n_fe;
    vc0 = n_vcyc;
    busy_seen = 1'b0;
    i_rxd = 1'b0;
    #(BIT_NS / 4);
    i_rxd = 1'b1;
    #(2 * BIT_NS);
    chk("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
    chk("glitch_busy_end", {31'd0, o_busy}, 32'd0);
    chk("glitch_vcyc", n_vcyc - vc0, 0);
    chk("glitch_fe", n_fe - fe0, 0);

    // 4: stop bit low, then line held low for two bytes
    fe0 = n_fe;
    vc0 = n_vcyc;
    send_frame(8'h3C, 1'b0, BIT_NS);
    #(20 * BIT_NS);
    chk("brk_fe", n_fe - fe0, 1);
    chk("brk_vcyc", n_vcyc - vc0, 0);
    chk("brk_busy", {31'd0, o_busy}, 32'd1);
    i_rxd = 1'b1;
    #(2 * BIT_NS);
    chk("brk_exit_busy", {31'd0, o_busy}, 32'd0);
    chk("brk_fe_total", n_fe - fe0, 1);

    // 5: overrun with consumer stalled
    @(posedge i_sysclk);
    #1 i_ready = 1'b0;
    ov0 = n_ov;
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1, BIT_NS);
    send_frame(8'h22, 1'b1, BIT_NS);
    #(2 * BIT_NS);
    chk("ovr_valid", {31'd0, o_valid}, 32'd1);
    chk("ovr_data", {24'd0, o_data}, 32'h11);
    chk("ovr_pulse", n_ov - ov0, 1);
    @(posedge i_sysclk);
    #1 i_ready = 1'b1;
    drain("ovr_drain");
    @(posedge i_sysclk);
    #1;
    chk("ovr_valid_clr", {31'd0, o_valid}, 32'd0);

    // 6: reset pulse in the middle of data bit 4, then a clean byte
    vc0 = n_vcyc;
    fork
      send_frame(8'hF0, 1'b1, BIT_NS);
      begin
        #(5 * BIT_NS + BIT_NS / 2);
        @(posedge i_sysclk);
        #1 i_rstn = 1'b0;
        @(posedge i_sysclk);
        #1 i_rstn = 1'b1;
        @(posedge i_sysclk);
        #1;
        chk("rst_mid_busy", {31'd0, o_busy}, 32'd0);
      end
    join
    #(BIT_NS);
    chk("rst_mid_lost", n_vcyc - vc0, 0);
    sb.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, BIT_NS);
    #(BIT_NS);
    drain("rst_mid_drain");
    chk("rst_mid_vcyc", n_vcyc - vc0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
